// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus master: FSM states,
// default phase timings and the RTC register map.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    HOLD = 3'd2,
    STRB = 3'd3,
    REC  = 3'd4
  } rtc_state_e;

  localparam int unsigned T_AD_DEF     = 2;
  localparam int unsigned T_HOLD_DEF   = 1;
  localparam int unsigned T_STROBE_DEF = 3;
  localparam int unsigned T_REC_DEF    = 2;

  localparam logic [7:0] SEC   = 8'h00;
  localparam logic [7:0] MIN   = 8'h02;
  localparam logic [7:0] HOUR  = 8'h04;
  localparam logic [7:0] DAY   = 8'h07;
  localparam logic [7:0] MONTH = 8'h08;
  localparam logic [7:0] YEAR  = 8'h09;
  localparam logic [7:0] REG_A = 8'h0A;
  localparam logic [7:0] REG_B = 8'h0B;
  localparam logic [7:0] REG_C = 8'h0C;

endpackage

// File: rtl/rtc_bus_ctrl.sv
// Single-transaction master for the RTC multiplexed address/data bus.
// Owns the only tri-state driver of Dato_sal; all pin controls are registered.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_AD     = T_AD_DEF,
  parameter int unsigned T_HOLD   = T_HOLD_DEF,
  parameter int unsigned T_STROBE = T_STROBE_DEF,
  parameter int unsigned T_REC    = T_REC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       AD,
  output logic       CS,
  output logic       RD,
  output logic       RW,
  inout  wire  [7:0] Dato_sal
);

  if (T_AD < 1 || T_AD > 15 || T_HOLD < 1 || T_HOLD > 15 ||
      T_STROBE < 1 || T_STROBE > 15 || T_REC < 1 || T_REC > 15) begin : g_bad_timing
    $error("rtc_bus_ctrl: every phase length must be in 1..15");
  end

  localparam logic [3:0] LD_AD     = 4'(T_AD - 1);
  localparam logic [3:0] LD_HOLD   = 4'(T_HOLD - 1);
  localparam logic [3:0] LD_STROBE = 4'(T_STROBE - 1);
  localparam logic [3:0] LD_REC    = 4'(T_REC - 1);

  rtc_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wr_q, wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       done_q, done_d;
  logic       ad_q, ad_d, cs_q, cs_d, rd_q, rd_d, rw_q, rw_d;
  logic       oe_q, oe_d;
  logic [7:0] dout_q, dout_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      done_q  <= 1'b0;
      ad_q    <= 1'b1;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      rw_q    <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      ad_q    <= ad_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
    end
  end

  // Pin controls are decoded from the next state so they register in step with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADDR;
          cnt_d   = LD_AD;
          wr_d    = wr;
          addr_d  = addr;
          wdata_d = wdata;
        end
      end
      ADDR: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          cnt_d   = LD_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = STRB;
          cnt_d   = LD_STROBE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STRB: begin
        if (cnt_q == 4'd0) begin
          state_d = REC;
          cnt_d   = LD_REC;
          if (!wr_q) rdata_d = Dato_sal;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REC: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    ad_d   = 1'b1;
    cs_d   = 1'b1;
    rd_d   = 1'b1;
    rw_d   = 1'b1;
    oe_d   = 1'b0;
    dout_d = addr_d;
    case (state_d)
      ADDR: begin
        cs_d = 1'b0;
        ad_d = 1'b0;
        oe_d = 1'b1;
      end
      HOLD: begin
        cs_d = 1'b0;
        oe_d = 1'b1;
      end
      STRB: begin
        cs_d = 1'b0;
        if (wr_d) begin
          rw_d   = 1'b0;
          oe_d   = 1'b1;
          dout_d = wdata_d;
        end else begin
          rd_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign Dato_sal = oe_q ? dout_q : 8'hzz;
  assign rdata    = rdata_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign AD       = ad_q;
  assign CS       = cs_q;
  assign RD       = rd_q;
  assign RW       = rw_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Self-checking bench for rtc_bus_ctrl: default-timing instance plus an
// all-ones timing instance, each with a simple RTC model on a pulled-up bus.
module tb_rtc_bus_ctrl;
  import rtc_bus_pkg::*;

  localparam int N0 = 1 + 2 + 1 + 3 + 2;
  localparam int N1 = 1 + 1 + 1 + 1 + 1;
  localparam logic [7:0] REL = 8'hFF;

  typedef struct packed {
    logic       ad;
    logic       cs;
    logic       rd;
    logic       rw;
    logic [7:0] bus;
  } pins_t;

  logic clk = 1'b0;
  logic reset;

  logic       start0, wr0;
  logic [7:0] addr0, wdata0, rdata0, rtcData0;
  logic       busy0, done0, ad0, cs0, rd0, rw0;
  wire  [7:0] bus0;

  logic       start1, wr1;
  logic [7:0] addr1, wdata1, rdata1, rtcData1;
  logic       busy1, done1, ad1, cs1, rd1, rw1;
  wire  [7:0] bus1;

  int nChecks = 0;
  int nFails  = 0;
  logic [7:0] expQ0[$];
  logic [7:0] expQ1[$];
  logic [7:0] lastRdata0;

  always #5 clk = ~clk;

  rtc_bus_ctrl #(.T_AD(2), .T_HOLD(1), .T_STROBE(3), .T_REC(2)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .wr(wr0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .busy(busy0), .done(done0), .AD(ad0), .CS(cs0), .RD(rd0), .RW(rw0),
    .Dato_sal(bus0)
  );

  rtc_bus_ctrl #(.T_AD(1), .T_HOLD(1), .T_STROBE(1), .T_REC(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .wr(wr1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .busy(busy1), .done(done1), .AD(ad1), .CS(cs1), .RD(rd1), .RW(rw1),
    .Dato_sal(bus1)
  );

  // RTC model: drives read data only while selected with RD low; bus pulled high otherwise.
  assign bus0 = (!cs0 && !rd0) ? rtcData0 : 8'hzz;
  assign bus1 = (!cs1 && !rd1) ? rtcData1 : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (bus0[i]);
    pullup (bus1[i]);
  end

  function automatic pins_t expPins(int cyc, int ta, int th, int ts, int tr, bit isWr,
                                    logic [7:0] a, logic [7:0] d, logic [7:0] rtc);
    pins_t p;
    p = '{ad: 1'b1, cs: 1'b1, rd: 1'b1, rw: 1'b1, bus: REL};
    if (cyc >= 1 && cyc <= ta) begin
      p.ad = 1'b0; p.cs = 1'b0; p.bus = a;
    end else if (cyc > ta && cyc <= ta + th) begin
      p.cs = 1'b0; p.bus = a;
    end else if (cyc > ta + th && cyc <= ta + th + ts) begin
      p.cs = 1'b0;
      if (isWr) begin p.rw = 1'b0; p.bus = d; end
      else begin p.rd = 1'b0; p.bus = rtc; end
    end
    if (tr < 0) p.bus = 8'hxx;
    return p;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nChecks++;
    if ({ad0, cs0, rd0, rw0} !== 4'b1111) begin
      nFails++; $display("[TB] FAIL reset_strobes: got %b want 1111", {ad0, cs0, rd0, rw0});
    end
    nChecks++;
    if (bus0 !== REL) begin
      nFails++; $display("[TB] FAIL reset_bus: got %h want %h (released)", bus0, REL);
    end
    nChecks++;
    if ({busy0, done0, rdata0} !== 10'd0) begin
      nFails++; $display("[TB] FAIL reset_status: busy %b done %b rdata %h want 0 0 00", busy0, done0, rdata0);
    end
    nChecks++;
    if ({busy1, done1, rdata1, ad1, cs1, rd1, rw1} !== {10'd0, 4'b1111}) begin
      nFails++; $display("[TB] FAIL reset_fast: busy %b done %b rdata %h pins %b", busy1, done1, rdata1, {ad1, cs1, rd1, rw1});
    end
    reset = 1'b0;
    lastRdata0 = 8'h00;
  endtask

  task automatic test_write();
    pins_t e;
    int dones = 0;
    logic [7:0] want;
    $display("[TB] write REG_B <= 86");
    wr0 = 1'b1; addr0 = REG_B; wdata0 = 8'h86; start0 = 1'b1;
    expQ0.push_back(lastRdata0);
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int cyc = 1; cyc <= N0; cyc++) begin
      e = expPins(cyc, 2, 1, 3, 2, 1'b1, REG_B, 8'h86, 8'h00);
      nChecks++;
      if ({ad0, cs0, rd0, rw0} !== {e.ad, e.cs, e.rd, e.rw}) begin
        nFails++; $display("[TB] FAIL write_strobes cyc %0d: got %b want %b", cyc, {ad0, cs0, rd0, rw0}, {e.ad, e.cs, e.rd, e.rw});
      end
      nChecks++;
      if (bus0 !== e.bus) begin
        nFails++; $display("[TB] FAIL write_bus cyc %0d: got %h want %h", cyc, bus0, e.bus);
      end
      nChecks++;
      if (busy0 !== (cyc < N0) || done0 !== (cyc == N0)) begin
        nFails++; $display("[TB] FAIL write_busy_done cyc %0d: got %b%b want %b%b", cyc, busy0, done0, cyc < N0, cyc == N0);
      end
      if (done0 === 1'b1) begin
        dones++;
        want = expQ0.pop_front();
        nChecks++;
        if (rdata0 !== want) begin
          nFails++; $display("[TB] FAIL write_rdata_kept: got %h want %h", rdata0, want);
        end
      end
      @(posedge clk); #1;
    end
    nChecks++;
    if (dones != 1) begin
      nFails++; $display("[TB] FAIL write_done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_read();
    pins_t e;
    int dones = 0;
    logic [7:0] want;
    $display("[TB] read HOUR, RTC returns 23");
    rtcData0 = 8'h23;
    wr0 = 1'b0; addr0 = HOUR; wdata0 = 8'hA5; start0 = 1'b1;
    expQ0.push_back(8'h23);
    lastRdata0 = 8'h23;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int cyc = 1; cyc <= N0; cyc++) begin
      e = expPins(cyc, 2, 1, 3, 2, 1'b0, HOUR, 8'hA5, 8'h23);
      nChecks++;
      if ({ad0, cs0, rd0, rw0} !== {e.ad, e.cs, e.rd, e.rw}) begin
        nFails++; $display("[TB] FAIL read_strobes cyc %0d: got %b want %b", cyc, {ad0, cs0, rd0, rw0}, {e.ad, e.cs, e.rd, e.rw});
      end
      nChecks++;
      if (bus0 !== e.bus) begin
        nFails++; $display("[TB] FAIL read_bus cyc %0d: got %h want %h", cyc, bus0, e.bus);
      end
      nChecks++;
      if (busy0 !== (cyc < N0) || done0 !== (cyc == N0)) begin
        nFails++; $display("[TB] FAIL read_busy_done cyc %0d: got %b%b want %b%b", cyc, busy0, done0, cyc < N0, cyc == N0);
      end
      if (done0 === 1'b1) begin
        dones++;
        want = expQ0.pop_front();
        nChecks++;
        if (rdata0 !== want) begin
          nFails++; $display("[TB] FAIL read_rdata: got %h want %h", rdata0, want);
        end
      end
      @(posedge clk); #1;
    end
    nChecks++;
    if (dones != 1 || rdata0 !== 8'h23) begin
      nFails++; $display("[TB] FAIL read_after: dones %0d rdata %h want 1 23", dones, rdata0);
    end
  endtask

  task automatic test_back_to_back();
    pins_t e;
    int dones = 0;
    logic [7:0] want;
    $display("[TB] read SEC with stray starts, then back-to-back read MONTH");
    rtcData0 = 8'h31;
    wr0 = 1'b0; addr0 = SEC; start0 = 1'b1;
    expQ0.push_back(8'h31);
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int cyc = 1; cyc <= N0; cyc++) begin
      e = expPins(cyc, 2, 1, 3, 2, 1'b0, SEC, 8'h00, 8'h31);
      nChecks++;
      if ({ad0, cs0, rd0, rw0, bus0} !== {e.ad, e.cs, e.rd, e.rw, e.bus}) begin
        nFails++; $display("[TB] FAIL ignore_pins cyc %0d: got %b %h want %b %h", cyc, {ad0, cs0, rd0, rw0}, bus0, {e.ad, e.cs, e.rd, e.rw}, e.bus);
      end
      if (done0 === 1'b1) begin
        dones++;
        want = expQ0.pop_front();
        nChecks++;
        if (rdata0 !== want) begin
          nFails++; $display("[TB] FAIL ignore_rdata: got %h want %h", rdata0, want);
        end
      end
      start0 = (cyc == 3 || cyc == 5 || cyc == N0);
      wr0    = (cyc == 3 || cyc == 5);
      addr0  = (cyc == N0) ? MONTH : 8'h55;
      wdata0 = 8'h66;
      @(posedge clk); #1;
    end
    nChecks++;
    if (dones != 1) begin
      nFails++; $display("[TB] FAIL ignore_done_count: got %0d want 1", dones);
    end
    start0 = 1'b0;
    rtcData0 = 8'h12;
    expQ0.push_back(8'h12);
    lastRdata0 = 8'h12;
    dones = 0;
    for (int cyc = 1; cyc <= N0; cyc++) begin
      e = expPins(cyc, 2, 1, 3, 2, 1'b0, MONTH, 8'h00, 8'h12);
      nChecks++;
      if ({ad0, cs0, rd0, rw0, bus0} !== {e.ad, e.cs, e.rd, e.rw, e.bus}) begin
        nFails++; $display("[TB] FAIL b2b_pins cyc %0d: got %b %h want %b %h", cyc, {ad0, cs0, rd0, rw0}, bus0, {e.ad, e.cs, e.rd, e.rw}, e.bus);
      end
      nChecks++;
      if (busy0 !== (cyc < N0) || done0 !== (cyc == N0)) begin
        nFails++; $display("[TB] FAIL b2b_busy_done cyc %0d: got %b%b want %b%b", cyc, busy0, done0, cyc < N0, cyc == N0);
      end
      if (done0 === 1'b1) begin
        dones++;
        want = expQ0.pop_front();
        nChecks++;
        if (rdata0 !== want) begin
          nFails++; $display("[TB] FAIL b2b_rdata: got %h want %h", rdata0, want);
        end
      end
      @(posedge clk); #1;
    end
    nChecks++;
    if (dones != 1) begin
      nFails++; $display("[TB] FAIL b2b_done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    logic [7:0] want;
    $display("[TB] reset during write strobe, then read REG_C");
    wr0 = 1'b1; addr0 = REG_A; wdata0 = 8'h26; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      if (cyc == 5) begin
        nChecks++;
        if ({rw0, bus0} !== {1'b0, 8'h26}) begin
          nFails++; $display("[TB] FAIL midreset_in_strb: rw %b bus %h want 0 26", rw0, bus0);
        end
        reset = 1'b1;
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    lastRdata0 = 8'h00;
    nChecks++;
    if ({ad0, cs0, rd0, rw0, bus0} !== {4'b1111, REL}) begin
      nFails++; $display("[TB] FAIL midreset_pins: got %b %h want 1111 %h", {ad0, cs0, rd0, rw0}, bus0, REL);
    end
    nChecks++;
    if ({busy0, done0, rdata0} !== 10'd0) begin
      nFails++; $display("[TB] FAIL midreset_status: busy %b done %b rdata %h want 0 0 00", busy0, done0, rdata0);
    end
    for (int cyc = 0; cyc < N0; cyc++) begin
      if (done0 === 1'b1) dones++;
      @(posedge clk); #1;
    end
    nChecks++;
    if (dones != 0) begin
      nFails++; $display("[TB] FAIL midreset_no_done: got %0d done pulses want 0", dones);
    end
    rtcData0 = 8'hC4;
    wr0 = 1'b0; addr0 = REG_C; start0 = 1'b1;
    expQ0.push_back(8'hC4);
    lastRdata0 = 8'hC4;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int cyc = 1; cyc <= N0 + 2; cyc++) begin
      if (done0 === 1'b1) begin
        dones++;
        want = expQ0.pop_front();
        nChecks++;
        if (rdata0 !== want || cyc != N0) begin
          nFails++; $display("[TB] FAIL postreset_read: rdata %h cyc %0d want %h cyc %0d", rdata0, cyc, want, N0);
        end
      end
      @(posedge clk); #1;
    end
    nChecks++;
    if (dones != 1) begin
      nFails++; $display("[TB] FAIL postreset_done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_fast_timing();
    pins_t e;
    int dones = 0;
    logic [7:0] want;
    $display("[TB] all-ones timing: read YEAR, RTC returns 47");
    rtcData1 = 8'h47;
    wr1 = 1'b0; addr1 = YEAR; wdata1 = 8'h00; start1 = 1'b1;
    expQ1.push_back(8'h47);
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int cyc = 1; cyc <= N1 + 1; cyc++) begin
      e = expPins(cyc, 1, 1, 1, 1, 1'b0, YEAR, 8'h00, 8'h47);
      nChecks++;
      if ({ad1, cs1, rd1, rw1, bus1} !== {e.ad, e.cs, e.rd, e.rw, e.bus}) begin
        nFails++; $display("[TB] FAIL fast_pins cyc %0d: got %b %h want %b %h", cyc, {ad1, cs1, rd1, rw1}, bus1, {e.ad, e.cs, e.rd, e.rw}, e.bus);
      end
      nChecks++;
      if (busy1 !== (cyc < N1) || done1 !== (cyc == N1)) begin
        nFails++; $display("[TB] FAIL fast_busy_done cyc %0d: got %b%b want %b%b", cyc, busy1, done1, cyc < N1, cyc == N1);
      end
      if (done1 === 1'b1) begin
        dones++;
        want = expQ1.pop_front();
        nChecks++;
        if (rdata1 !== want) begin
          nFails++; $display("[TB] FAIL fast_rdata: got %h want %h", rdata1, want);
        end
      end
      @(posedge clk); #1;
    end
    nChecks++;
    if (dones != 1) begin
      nFails++; $display("[TB] FAIL fast_done_count: got %0d want 1", dones);
    end
  endtask

  initial begin
    reset = 1'b1;
    start0 = 1'b0; wr0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00; rtcData0 = 8'h00;
    start1 = 1'b0; wr1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00; rtcData1 = 8'h00;
    lastRdata0 = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_fast_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
